// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default sizes,
// the per-cycle operation encoding and a constant log2 helper.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // What the FIFO does this cycle once full/empty gating has been applied.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int log2Ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately left unreset.
module fifo_mem_dp #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [1 << AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds, overflow/underflow pulses and selectable FWFT/registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              din,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [log2Ceil(DEPTH):0]      count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = log2Ceil(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;
  fifo_op_e         op;

  // Flags come purely from the count register, so request inputs never
  // reach them combinationally.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    op          = fifo_op_e'({rd_acc, wr_acc});
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en & full;
    underflow_d = rd_en & empty;
    unique case (op)
      OP_WR: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      OP_RD: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // FWFT presents the head word directly; registered mode captures it on pop
  // and holds it otherwise.
  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = rd_data;
    end else begin : g_regread
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else if (rd_acc) dout_q <= rd_data;
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a registered-read and an FWFT instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         wrEn, rdEn;
  logic [W-1:0] din;

  logic [W-1:0] doutReg, doutFw;
  logic         fullReg, emptyReg, afReg, aeReg, ovfReg, unfReg;
  logic         fullFw, emptyFw, afFw, aeFw, ovfFw, unfFw;
  logic [3:0]   countReg, countFw;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] modelQ [$];
  logic [W-1:0] expDout;
  logic         expOvf, expUnf;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
  ) uReg (
    .clk(clk), .rst(rst), .wr_en(wrEn), .din(din), .rd_en(rdEn),
    .dout(doutReg), .full(fullReg), .empty(emptyReg),
    .almost_full(afReg), .almost_empty(aeReg), .count(countReg),
    .overflow(ovfReg), .underflow(unfReg)
  );

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
  ) uFwft (
    .clk(clk), .rst(rst), .wr_en(wrEn), .din(din), .rd_en(rdEn),
    .dout(doutFw), .full(fullFw), .empty(emptyFw),
    .almost_full(afFw), .almost_empty(aeFw), .count(countFw),
    .overflow(ovfFw), .underflow(unfFw)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare both instances against the model's view of the queue.
  task automatic checkState();
    int n;
    n = modelQ.size();
    checkOutput("count_reg", 32'(countReg), 32'(n));
    checkOutput("count_fw",  32'(countFw),  32'(n));
    checkOutput("full",      32'(fullReg),  32'(n == D));
    checkOutput("empty",     32'(emptyReg), 32'(n == 0));
    checkOutput("afull",     32'(afReg),    32'(n >= AF));
    checkOutput("aempty",    32'(aeReg),    32'(n <= AE));
    checkOutput("full_fw",   32'(fullFw),   32'(n == D));
    checkOutput("empty_fw",  32'(emptyFw),  32'(n == 0));
    checkOutput("ovf",       32'(ovfReg),   32'(expOvf));
    checkOutput("unf",       32'(unfReg),   32'(expUnf));
    checkOutput("ovf_fw",    32'(ovfFw),    32'(expOvf));
    checkOutput("unf_fw",    32'(unfFw),    32'(expUnf));
    checkOutput("dout_reg",  32'(doutReg),  32'(expDout));
    if (n > 0) checkOutput("dout_fw", 32'(doutFw), 32'(modelQ[0]));
  endtask

  // One clock: drive the request, let the edge happen, advance the model.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [W-1:0] data);
    int n;
    wrEn = wr;
    rdEn = rd;
    din  = data;
    @(posedge clk);
    #1;
    n      = modelQ.size();
    expOvf = wr && (n == D);
    expUnf = rd && (n == 0);
    if (rd && n > 0) expDout = modelQ.pop_front();
    if (wr && n < D) modelQ.push_back(data);
    wrEn = 1'b0;
    rdEn = 1'b0;
    checkState();
  endtask

  task automatic modelReset();
    modelQ.delete();
    expDout = '0;
    expOvf  = 1'b0;
    expUnf  = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    wrEn = 1'b0;
    rdEn = 1'b0;
    din  = '0;
    modelReset();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkState();

    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, W'(i));
    applyStimulus(1'b1, 1'b0, 8'hFF);
    applyStimulus(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("dout_hold", 32'(doutReg), 32'h08);
    applyStimulus(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, W'(8'h10 + i));
    applyStimulus(1'b1, 1'b1, 8'h14);
    checkOutput("both_cnt4", 32'(countReg), 32'd4);
    while (modelQ.size() < D) applyStimulus(1'b1, 1'b0, W'($urandom));
    applyStimulus(1'b1, 1'b1, 8'hEE);
    checkOutput("both_full", 32'(countReg), 32'd7);
    while (modelQ.size() > 0) applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("both_empty", 32'(countReg), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 20; i++) applyStimulus(1'b1, (i % 3) != 0, W'(8'h40 + i));
    for (int i = 0; i < 400; i++) applyStimulus(1'($urandom), 1'($urandom), W'($urandom));

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 1'b0, 8'hA5);
    checkOutput("fwft_a5", 32'(doutFw), 32'hA5);
    applyStimulus(1'b1, 1'b0, 8'hB6);
    applyStimulus(1'b1, 1'b0, 8'hC7);

    #2 rst = 1'b1;
    #1;
    checkOutput("arst_cnt",   32'(countReg), 32'd0);
    checkOutput("arst_empty", 32'(emptyReg), 32'd1);
    checkOutput("arst_cntfw", 32'(countFw),  32'd0);
    checkOutput("arst_dout",  32'(doutReg),  32'd0);
    #1 rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 1'b0, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 100; i++) applyStimulus(1'($urandom), 1'($urandom), W'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
